// File: rtl/render_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Package : render_pkg                                                    |
// | Brief   : Tile codes, tile-map geometry and display colours shared by   |
// |           the level modules and the tile renderer.                      |
// | Rev     : 1.0                                                           |
// ---------------------------------------------------------------------------
package render_pkg;

  // Tile-map geometry in cells; the map itself carries one extra hidden column.
  localparam int TILES_X = 16;
  localparam int TILES_Y = 12;

  // Tile codes written into background[y][x] by the level modules.
  typedef enum logic [7:0] {
    BDR = 8'd0,
    SKY = 8'd1,
    BLK = 8'd2,
    GND = 8'd3,
    TKN = 8'd4,
    CK1 = 8'd5,
    CK2 = 8'd6
  } tile_t;

  // 12-bit {R,G,B} colours.
  localparam logic [11:0] COL_BDR    = 12'h000;
  localparam logic [11:0] COL_SKY    = 12'h6AF;
  localparam logic [11:0] COL_BLK    = 12'h840;
  localparam logic [11:0] COL_GND    = 12'h0A0;
  localparam logic [11:0] COL_TKN    = 12'hFD0;
  localparam logic [11:0] COL_CLK    = 12'hFFF;
  localparam logic [11:0] COL_MARIO  = 12'hF00;
  localparam logic [11:0] COL_GOOMBA = 12'h630;
  localparam logic [11:0] COL_BAD    = 12'hF0F;

endpackage
`default_nettype wire

// File: rtl/sprite_box_hit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : sprite_box_hit                                                |
// | Brief   : Combinational test of a pixel against a square sprite box     |
// |           whose top-left corner is (box_x, box_y). Signed arithmetic so |
// |           negative or off-screen boxes simply never match.              |
// | Rev     : 1.0                                                           |
// ---------------------------------------------------------------------------
module sprite_box_hit #(
  parameter int SIZE = 42
) (
  input  logic signed [31:0] px,
  input  logic signed [31:0] py,
  input  logic signed [31:0] box_x,
  input  logic signed [31:0] box_y,
  output logic               hit
);

  // Half-open interval on both axes: [box, box+SIZE).
  assign hit = (px >= box_x) && (px < box_x + SIZE) &&
               (py >= box_y) && (py < box_y + SIZE);

endmodule
`default_nettype wire

// File: rtl/tile_renderer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : tile_renderer                                                 |
// | Brief   : Per-pixel tile-map lookup with Mario/Goomba sprite overlay.   |
// |           Two register stages from raster position to rgb; syncs and    |
// |           video_on are delayed to match.                                |
// | Rev     : 1.0                                                           |
// ---------------------------------------------------------------------------
module tile_renderer
  import render_pkg::*;
#(
  parameter int CHARACTER_WIDTH = 42,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int BLOCK_WIDTH     = 40
) (
  input  logic                                 vga_clock,
  input  logic                                 reset,
  input  logic [9:0]                           pixel_x,
  input  logic [9:0]                           pixel_y,
  input  logic                                 video_on,
  input  logic                                 hsync_in,
  input  logic                                 vsync_in,
  input  logic [TILES_Y-1:0][TILES_X:0][7:0]   background,
  input  logic signed [31:0]                   mario_x,
  input  logic signed [31:0]                   mario_y,
  input  logic signed [31:0]                   goomba_x,
  input  logic signed [31:0]                   goomba_y,
  output logic [11:0]                          rgb,
  output logic                                 hsync_out,
  output logic                                 vsync_out,
  output logic                                 video_on_out,
  output logic                                 bad_tile
);

  localparam int SUB_W = $clog2(BLOCK_WIDTH);
  localparam int COL_W = $clog2(TILES_X + 1);
  localparam int ROW_W = $clog2(TILES_Y + 1);

  localparam logic [SUB_W-1:0] c_sub_last = SUB_W'(BLOCK_WIDTH - 1);
  localparam logic [9:0]       c_x_last   = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0]       c_x_end    = 10'(SCREEN_WIDTH);
  localparam logic [9:0]       c_y_end    = 10'(SCREEN_HEIGHT);
  localparam logic [ROW_W-1:0] c_rows     = ROW_W'(TILES_Y);

  // Tile counter state: the position of the last pixel seen with video_on.
  logic [SUB_W-1:0] r_sub_x, r_sub_y;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_synced;

  // Current-pixel tile position and next counter values.
  logic [SUB_W-1:0] w_sub_x, w_sub_y, w_sub_y_nxt;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row, w_row_nxt;
  logic             w_line_start, w_vis;
  logic             w_mario_hit, w_goomba_hit;
  logic signed [31:0] w_px, w_py;

  // Stage 1 registers.
  logic [7:0] r_tile;
  logic       r_mario_hit, r_goomba_hit, r_vis1, r_hs1, r_vs1, r_vo1;

  // Stage 2 registers.
  logic [11:0] r_rgb;
  logic        r_hs2, r_vs2, r_vo2, r_bad;

  assign w_line_start = video_on && (pixel_x == 10'd0);
  // Nothing is shown after reset until a line start re-aligns the column count.
  assign w_vis = video_on && (r_synced || w_line_start) &&
                 (pixel_x < c_x_end) && (pixel_y < c_y_end);
  assign w_px  = signed'({22'd0, pixel_x});
  assign w_py  = signed'({22'd0, pixel_y});

  // Derive this pixel's tile cell from the previous pixel's counters.
  always_comb begin
    w_sub_x = r_sub_x;
    w_col   = r_col;
    if (w_line_start) begin
      w_sub_x = '0;
      w_col   = '0;
    end else if (video_on) begin
      if (r_sub_x == c_sub_last) begin
        w_sub_x = '0;
        w_col   = r_col + COL_W'(1);
      end else begin
        w_sub_x = r_sub_x + SUB_W'(1);
      end
    end

    w_sub_y = r_sub_y;
    w_row   = r_row;
    if ((pixel_x == 10'd0) && (pixel_y == 10'd0)) begin
      w_sub_y = '0;
      w_row   = '0;
    end

    // The row steps after the last pixel of a line so the next line sees it.
    w_sub_y_nxt = w_sub_y;
    w_row_nxt   = w_row;
    if (video_on && (pixel_x == c_x_last)) begin
      if (w_sub_y == c_sub_last) begin
        w_sub_y_nxt = '0;
        w_row_nxt   = w_row + ROW_W'(1);
      end else begin
        w_sub_y_nxt = w_sub_y + SUB_W'(1);
      end
    end
  end

  // Tile counter state update.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      r_sub_x  <= '0;
      r_col    <= '0;
      r_sub_y  <= '0;
      r_row    <= '0;
      r_synced <= 1'b0;
    end else begin
      r_sub_x  <= w_sub_x;
      r_col    <= w_col;
      r_sub_y  <= w_sub_y_nxt;
      r_row    <= w_row_nxt;
      r_synced <= r_synced || w_line_start;
    end
  end

  sprite_box_hit #(.SIZE(CHARACTER_WIDTH)) u_mario_hit (
    .px    (w_px),
    .py    (w_py),
    .box_x (mario_x),
    .box_y (mario_y),
    .hit   (w_mario_hit)
  );

  sprite_box_hit #(.SIZE(CHARACTER_WIDTH)) u_goomba_hit (
    .px    (w_px),
    .py    (w_py),
    .box_x (goomba_x),
    .box_y (goomba_y),
    .hit   (w_goomba_hit)
  );

  // Stage 1: register tile code, sprite hits and delayed control.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      r_tile       <= '0;
      r_mario_hit  <= 1'b0;
      r_goomba_hit <= 1'b0;
      r_vis1       <= 1'b0;
      r_hs1        <= 1'b0;
      r_vs1        <= 1'b0;
      r_vo1        <= 1'b0;
    end else begin
      r_tile       <= (w_row < c_rows) ? background[w_row][w_col] : BDR;
      r_mario_hit  <= w_mario_hit;
      r_goomba_hit <= w_goomba_hit;
      r_vis1       <= w_vis;
      r_hs1        <= hsync_in;
      r_vs1        <= vsync_in;
      r_vo1        <= video_on;
    end
  end

  // Stage 2: prioritised colour select and sticky unknown-tile flag.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      r_rgb <= '0;
      r_hs2 <= 1'b0;
      r_vs2 <= 1'b0;
      r_vo2 <= 1'b0;
      r_bad <= 1'b0;
    end else begin
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_vo2 <= r_vo1;
      if (!r_vis1) begin
        r_rgb <= 12'h000;
      end else if (r_mario_hit) begin
        r_rgb <= COL_MARIO;
      end else if (r_goomba_hit) begin
        r_rgb <= COL_GOOMBA;
      end else begin
        case (r_tile)
          BDR:      r_rgb <= COL_BDR;
          SKY:      r_rgb <= COL_SKY;
          BLK:      r_rgb <= COL_BLK;
          GND:      r_rgb <= COL_GND;
          TKN:      r_rgb <= COL_TKN;
          CK1, CK2: r_rgb <= COL_CLK;
          default: begin
            r_rgb <= COL_BAD;
            r_bad <= 1'b1;
          end
        endcase
      end
    end
  end

  assign rgb          = r_rgb;
  assign hsync_out    = r_hs2;
  assign vsync_out    = r_vs2;
  assign video_on_out = r_vo2;
  assign bad_tile     = r_bad;

endmodule
`default_nettype wire
